nios_mult_pipe_cell: RTL and testbench
======================================

Name: nios_mult_pipe_cell

Overview:
- Parametrised, pipelined integer multiplier for the CPU execute/memory stage. Successor to the fixed 32x32 low-half multiply cell.
- Adds:
  - a configurable operand width and pipeline depth;
  - signed/unsigned operand modes and high-half result selection (MUL / MULXUU / MULXSU / MULXSS);
  - valid tracking, stall hold and flush.
- Sits between the A-stage operand muxes and the writeback result mux.

Parameters:
- DATA_W, 32, operand and result width. Must be even, 16..64.
- LAT, 2, cycles from accepted operands to result valid. Range 1..4.
- SPLIT_W, 16, partial-product slice width. Must divide DATA_W.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- A_mul_valid  in  1  operands and op valid this cycle.
- A_mul_src1  in  DATA_W  multiplicand.
- A_mul_src2  in  DATA_W  multiplier.
- A_mul_op  in  2  operation select: 00 MUL (low half), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS. Ops 01..11 return the high half.
- A_mul_stall  in  1  freeze all pipeline stages.
- A_mul_flush  in  1  kill all in-flight operations.
- A_mul_cell_result  out  DATA_W  selected product half.
- A_mul_cell_valid  out  1  result valid, one pulse per accepted op.
- A_mul_busy  out  1  any stage holds a valid op.

Behaviour:
- Clock and reset are fixed: single clock clk; reset_n is asynchronous, active-low. While reset_n=0, every pipeline register, valid bit and output is 0: A_mul_cell_result=0, A_mul_cell_valid=0, A_mul_busy=0.
- Arithmetic:
  - Extend each operand to DATA_W+1 bits: sign-extend if its mode is signed, else zero-extend.
  - Form the full 2*DATA_W product, modulo 2^(2*DATA_W).
  - MUL returns bits [DATA_W-1:0]. The other ops return bits [2*DATA_W-1:DATA_W].
  - MUL low half is identical for signed and unsigned operands.
- Structure:
  - Stage 1 registers partial products of SPLIT_W slices, with sign handling on the top slices. This may map to dedicated multipliers.
  - Remaining stages sum the partial products and register the result.
  - For LAT=1, a single register holds the complete selected result.
  - Op and valid travel with the data through every stage.
- Latency: an op presented with A_mul_valid=1 at edge N with no stall produces A_mul_cell_valid=1 and its result after edge N+LAT-1. Throughput is one op per cycle.
- Stall: A_mul_stall=1 holds every stage, including its valid bit, and ignores the inputs that cycle. Outputs stay constant, so A_mul_cell_valid may remain high across a stall. The consumer counts one result per cycle in which valid=1 and stall=0.
- Flush:
  - A_mul_flush=1 synchronously clears all valid bits at the next edge and discards any input that cycle.
  - Data registers may keep stale values, but A_mul_cell_result is forced to 0 whenever valid=0.
  - Flush has priority over stall.
- Simultaneous valid input with stall=1: the input is not accepted, and the issuer must hold it.
- A_mul_busy = OR of all stage valid bits, registered-path only.
- Reset asserted mid-operation drops all ops immediately. After release, the pipe is empty and no spurious valid appears.
- Result is 0 whenever A_mul_cell_valid=0.

Test Plan (DATA_W=32, LAT=2 unless stated):
- Basic ops:
  - MUL, src1=0x00010003, src2=0x00020005 -> result 0x000B000F, valid exactly 2 cycles after issue.
  - Same operands with MULXUU -> 0x00000002.
- Sign modes, both operands 0xFFFFFFFF:
  - MULXUU -> 0xFFFFFFFE.
  - MULXSU -> 0xFFFFFFFF.
  - MULXSS -> 0x00000000.
  - MUL -> 0x00000001.
- Corner case: src1=src2=0x80000000 with MULXSS -> 0x40000000; with MUL -> 0x00000000.
- Back-to-back and stall:
  - Issue 4 ops on consecutive cycles and assert stall for 3 cycles mid-stream -> 4 correct results in order, no duplicates or drops when counting valid&&!stall, busy high throughout.
- Flush:
  - Issue 2 ops, flush one cycle later -> no valid pulses follow, result=0, busy=0 next cycle.
  - An op issued in the cycle after the flush completes normally.
- Reset and parameter sweep:
  - Assert reset_n=0 with 2 ops in flight -> outputs 0 immediately (asynchronous), no valid after release.
  - Rerun the random compare against a reference model for DATA_W=16/64 and LAT=1/4 with SPLIT_W=16.

Source files
------------

// File: rtl/nios_mult_pipe_cell_if.sv
// Operand/result bundle between the A-stage operand muxes and the multiplier cell.
interface nios_mult_pipe_cell_if #(
    parameter int unsigned DATA_W = 32
);
    logic              A_mul_valid;
    logic [DATA_W-1:0] A_mul_src1;
    logic [DATA_W-1:0] A_mul_src2;
    logic [1:0]        A_mul_op;
    logic              A_mul_stall;
    logic              A_mul_flush;
    logic [DATA_W-1:0] A_mul_cell_result;
    logic              A_mul_cell_valid;
    logic              A_mul_busy;

    // Issuing side: A-stage control and writeback consumer.
    modport master (
        output A_mul_valid, A_mul_src1, A_mul_src2, A_mul_op, A_mul_stall, A_mul_flush,
        input  A_mul_cell_result, A_mul_cell_valid, A_mul_busy
    );

    // Multiplier cell side.
    modport slave (
        input  A_mul_valid, A_mul_src1, A_mul_src2, A_mul_op, A_mul_stall, A_mul_flush,
        output A_mul_cell_result, A_mul_cell_valid, A_mul_busy
    );
endinterface

// File: rtl/nios_mult_pipe_cell.sv
// Pipelined DATA_W x DATA_W multiplier: MUL low half, MULXUU/MULXSU/MULXSS high half.
// Stage 1 registers signed SPLIT_W-slice partial products; the next stage sums them and
// registers the selected half; any further stages are plain delay registers.
module nios_mult_pipe_cell #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LAT     = 2,
    parameter int unsigned SPLIT_W = 16
) (
    input logic                  clk,
    input logic                  reset_n,
    nios_mult_pipe_cell_if.slave mul_if
);

    localparam int unsigned NS     = DATA_W / SPLIT_W;
    localparam int unsigned NPP    = NS * NS;
    localparam int unsigned PP_W   = 2 * SPLIT_W + 2;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned RES_N  = (LAT > 1) ? LAT - 1 : 1;
    localparam int unsigned OFF    = (LAT > 1) ? 1 : 0;

    logic                     w_a_sgn;
    logic                     w_b_sgn;
    logic signed [SPLIT_W:0]  w_a_slc;
    logic signed [SPLIT_W:0]  w_b_slc;
    logic signed [PP_W-1:0]   w_pp     [NPP];
    logic signed [PP_W-1:0]   w_sum_pp [NPP];
    logic [1:0]               w_sum_op;
    logic signed [PROD_W-1:0] w_prod;
    logic [DATA_W-1:0]        w_sel;
    logic                     w_accept;

    logic [LAT-1:0]                 r_vld;
    logic [LAT:0]                   w_vld_cat;
    logic [RES_N*DATA_W-1:0]        r_res;
    logic [(RES_N+1)*DATA_W-1:0]    w_res_cat;
    logic                           r_busy;

    assign w_a_sgn  = mul_if.A_mul_op[1];
    assign w_b_sgn  = (mul_if.A_mul_op == 2'b11);
    assign w_accept = mul_if.A_mul_valid && !mul_if.A_mul_stall && !mul_if.A_mul_flush;

    // Slice partial products; only the top slice of a signed operand carries its sign bit.
    always_comb begin
        w_a_slc = '0;
        w_b_slc = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NS; j++) begin
                w_a_slc = {((i == NS - 1) && w_a_sgn) ? mul_if.A_mul_src1[DATA_W-1] : 1'b0,
                           mul_if.A_mul_src1[i*SPLIT_W +: SPLIT_W]};
                w_b_slc = {((j == NS - 1) && w_b_sgn) ? mul_if.A_mul_src2[DATA_W-1] : 1'b0,
                           mul_if.A_mul_src2[j*SPLIT_W +: SPLIT_W]};
                w_pp[i*NS+j] = PP_W'(w_a_slc) * PP_W'(w_b_slc);
            end
        end
    end

    if (LAT > 1) begin : g_s1
        logic signed [PP_W-1:0] r_pp [NPP];
        logic [1:0]             r_op;

        // Partial-product register; loads only on an accepted op, stale data otherwise.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < NPP; k++) r_pp[k] <= '0;
                r_op <= '0;
            end else if (w_accept) begin
                r_pp <= w_pp;
                r_op <= mul_if.A_mul_op;
            end
        end

        assign w_sum_pp = r_pp;
        assign w_sum_op = r_op;
    end else begin : g_s1_bypass
        assign w_sum_pp = w_pp;
        assign w_sum_op = mul_if.A_mul_op;
    end

    // Sum shifted partial products into the full product and pick the requested half.
    always_comb begin
        w_prod = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NS; j++) begin
                w_prod = w_prod + (PROD_W'(w_sum_pp[i*NS+j]) <<< (SPLIT_W * (i + j)));
            end
        end
        w_sel = (w_sum_op == 2'b00) ? w_prod[DATA_W-1:0] : w_prod[PROD_W-1:DATA_W];
    end

    // Input valid concatenated under the stage valids; shifting it in advances the pipe.
    assign w_vld_cat = {r_vld, mul_if.A_mul_valid};
    // Result chain input is zeroed when empty so the output is 0 whenever valid is 0.
    assign w_res_cat = {r_res, w_vld_cat[OFF] ? w_sel : DATA_W'(0)};

    // Valid/result pipeline: flush beats stall, stall freezes everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld  <= '0;
            r_res  <= '0;
            r_busy <= 1'b0;
        end else if (mul_if.A_mul_flush) begin
            r_vld  <= '0;
            r_res  <= '0;
            r_busy <= 1'b0;
        end else if (!mul_if.A_mul_stall) begin
            r_vld  <= w_vld_cat[LAT-1:0];
            r_res  <= w_res_cat[RES_N*DATA_W-1:0];
            r_busy <= |w_vld_cat[LAT-1:0];
        end
    end

    assign mul_if.A_mul_cell_valid  = w_vld_cat[LAT];
    assign mul_if.A_mul_cell_result = w_res_cat[(RES_N+1)*DATA_W-1 -: DATA_W];
    assign mul_if.A_mul_busy        = r_busy;

endmodule

// File: tb/tb_nios_mult_pipe_cell.sv
// Bench for nios_mult_pipe_cell: directed checks on a 32-bit LAT=2 cell, then a randomized
// compare of 32/LAT2, 16/LAT1 and 64/LAT4 cells against a plain-arithmetic model.
module tb_nios_mult_pipe_cell;

    logic clk = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    always #5 clk = ~clk;

    nios_mult_pipe_cell_if #(.DATA_W(32)) mif0 ();
    nios_mult_pipe_cell_if #(.DATA_W(16)) mif1 ();
    nios_mult_pipe_cell_if #(.DATA_W(64)) mif2 ();

    nios_mult_pipe_cell #(.DATA_W(32), .LAT(2), .SPLIT_W(16)) u0 (.clk(clk), .reset_n(reset_n), .mul_if(mif0));
    nios_mult_pipe_cell #(.DATA_W(16), .LAT(1), .SPLIT_W(16)) u1 (.clk(clk), .reset_n(reset_n), .mul_if(mif1));
    nios_mult_pipe_cell #(.DATA_W(64), .LAT(4), .SPLIT_W(16)) u2 (.clk(clk), .reset_n(reset_n), .mul_if(mif2));

    // Reference: extend to w+1 bits by mode, multiply exactly, take the requested half.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] op, input int w);
        logic [63:0]         m, am, bm;
        logic signed [131:0] ea, eb, p;
        m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        am = a & m;
        bm = b & m;
        ea = $signed({68'd0, am});
        eb = $signed({68'd0, bm});
        if (op[1] && am[w-1])         ea = ea - (132'sd1 <<< w);
        if (op == 2'b11 && bm[w-1])   eb = eb - (132'sd1 <<< w);
        p = ea * eb;
        if (op == 2'b00) return 64'(p) & m;
        return 64'(p >> w) & m;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        mif0.A_mul_valid = 0; mif0.A_mul_src1 = '0; mif0.A_mul_src2 = '0; mif0.A_mul_op = 0;
        mif0.A_mul_stall = 0; mif0.A_mul_flush = 0;
        mif1.A_mul_valid = 0; mif1.A_mul_src1 = '0; mif1.A_mul_src2 = '0; mif1.A_mul_op = 0;
        mif1.A_mul_stall = 0; mif1.A_mul_flush = 0;
        mif2.A_mul_valid = 0; mif2.A_mul_src1 = '0; mif2.A_mul_src2 = '0; mif2.A_mul_op = 0;
        mif2.A_mul_stall = 0; mif2.A_mul_flush = 0;
    endtask

    // Issue one op on the 32-bit cell and check it appears exactly after edge N+1.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        mif0.A_mul_valid = 1; mif0.A_mul_op = op; mif0.A_mul_src1 = a; mif0.A_mul_src2 = b;
        @(posedge clk); #1;
        mif0.A_mul_valid = 0;
        check({tag, "_early"}, 64'(mif0.A_mul_cell_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_vld"}, 64'(mif0.A_mul_cell_valid), 64'd1);
        check(tag, 64'(mif0.A_mul_cell_result), 64'(exp));
    endtask

    // Consumer-side scoreboard for cell d: one result per cycle with valid=1 and stall=0.
    task automatic score(input int d, input logic v, input logic st, input logic [63:0] res);
        logic [63:0] e;
        logic        got;
        e = '0;
        got = 0;
        if (v && !st) begin
            case (d)
                0: if (q0.size() != 0) begin e = q0.pop_front(); got = 1; end
                1: if (q1.size() != 0) begin e = q1.pop_front(); got = 1; end
                default: if (q2.size() != 0) begin e = q2.pop_front(); got = 1; end
            endcase
            if (!got) check($sformatf("rnd%0d_spurious", d), 64'(got), 64'd1);
            else      check($sformatf("rnd%0d_result", d), res, e);
        end else if (!v) begin
            check($sformatf("rnd%0d_zero", d), res, 64'd0);
        end
    endtask

    initial begin
        logic [31:0] sa[4], sb[4];
        logic [1:0]  so[4];
        logic [63:0] exp4[4];
        int          oi, ri;
        logic        rv, st;
        logic [1:0]  op;
        logic [63:0] a, b;

        reset_n = 1'b1;
        idle_all();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", 64'(mif0.A_mul_cell_result), 64'd0);
        check("rst_valid",  64'(mif0.A_mul_cell_valid),  64'd0);
        check("rst_busy",   64'(mif0.A_mul_busy),        64'd0);
        check("rst_valid64", 64'(mif2.A_mul_cell_valid), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_basic",    2'b00, 32'h00010003, 32'h00020005, 32'h000B000F);
        run_op("mulxuu_basic", 2'b01, 32'h00010003, 32'h00020005, 32'h00000002);
        run_op("mulxuu_ones",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mulxsu_ones",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulxss_ones",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_op("mul_ones",     2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_op("mulxss_min",   2'b11, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mul_min",      2'b00, 32'h80000000, 32'h80000000, 32'h00000000);

        // Four back-to-back ops with a three-cycle stall while the third is presented.
        for (int i = 0; i < 4; i++) begin
            sa[i] = $urandom(); sb[i] = $urandom(); so[i] = 2'($urandom_range(0, 3));
            exp4[i] = ref_mul(64'(sa[i]), 64'(sb[i]), so[i], 32);
        end
        @(posedge clk); #1;
        oi = 0; ri = 0;
        for (int c = 0; c < 12; c++) begin
            mif0.A_mul_stall = (c >= 2 && c <= 4);
            mif0.A_mul_valid = (oi < 4);
            if (oi < 4) begin
                mif0.A_mul_src1 = sa[oi]; mif0.A_mul_src2 = sb[oi]; mif0.A_mul_op = so[oi];
            end
            @(negedge clk);
            if (c >= 1 && c <= 8) check($sformatf("b2b_busy_c%0d", c), 64'(mif0.A_mul_busy), 64'd1);
            if (c == 9)           check("b2b_idle", 64'(mif0.A_mul_busy), 64'd0);
            if (mif0.A_mul_cell_valid && !mif0.A_mul_stall) begin
                if (ri < 4) check($sformatf("b2b_res%0d", ri), 64'(mif0.A_mul_cell_result), exp4[ri]);
                ri++;
            end
            if (mif0.A_mul_valid && !mif0.A_mul_stall) oi++;
            @(posedge clk); #1;
        end
        mif0.A_mul_stall = 0; mif0.A_mul_valid = 0;
        check("b2b_count", 64'(ri), 64'd4);

        // Flush with two ops in flight, then an op issued right after completes normally.
        mif0.A_mul_valid = 1; mif0.A_mul_op = 2'b00; mif0.A_mul_src1 = 32'd7; mif0.A_mul_src2 = 32'd9;
        @(posedge clk); #1;
        mif0.A_mul_src1 = 32'd11; mif0.A_mul_src2 = 32'd13;
        @(posedge clk); #1;
        mif0.A_mul_valid = 0; mif0.A_mul_flush = 1;
        @(posedge clk); #1;
        mif0.A_mul_flush = 0;
        check("flush_valid",  64'(mif0.A_mul_cell_valid),  64'd0);
        check("flush_result", 64'(mif0.A_mul_cell_result), 64'd0);
        check("flush_busy",   64'(mif0.A_mul_busy),        64'd0);
        run_op("post_flush", 2'b00, 32'd3, 32'd5, 32'd15);

        // Asynchronous reset with two ops in flight.
        @(posedge clk); #1;
        mif0.A_mul_valid = 1; mif0.A_mul_op = 2'b00; mif0.A_mul_src1 = 32'd6; mif0.A_mul_src2 = 32'd7;
        @(posedge clk); #1;
        mif0.A_mul_src1 = 32'd8;
        @(posedge clk); #1;
        mif0.A_mul_valid = 0;
        check("prerst_valid", 64'(mif0.A_mul_cell_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid",  64'(mif0.A_mul_cell_valid),  64'd0);
        check("arst_result", 64'(mif0.A_mul_cell_result), 64'd0);
        check("arst_busy",   64'(mif0.A_mul_busy),        64'd0);
        @(negedge clk) reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("postrst_valid_c%0d", c), 64'(mif0.A_mul_cell_valid | mif0.A_mul_busy), 64'd0);
        end

        // Random traffic with stalls on all three parameterisations.
        for (int c = 0; c < 408; c++) begin
            rv = (c < 400) && ($urandom_range(0, 3) != 0);
            st = (c < 400) && ($urandom_range(0, 5) == 0);
            op = 2'($urandom_range(0, 3));
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = 64'h8000_0000_8000_8000;
            mif0.A_mul_valid = rv; mif0.A_mul_stall = st; mif0.A_mul_op = op;
            mif0.A_mul_src1 = a[31:0]; mif0.A_mul_src2 = b[31:0];
            mif1.A_mul_valid = rv; mif1.A_mul_stall = st; mif1.A_mul_op = op;
            mif1.A_mul_src1 = a[15:0]; mif1.A_mul_src2 = b[15:0];
            mif2.A_mul_valid = rv; mif2.A_mul_stall = st; mif2.A_mul_op = op;
            mif2.A_mul_src1 = a; mif2.A_mul_src2 = b;
            @(negedge clk);
            score(0, mif0.A_mul_cell_valid, st, 64'(mif0.A_mul_cell_result));
            score(1, mif1.A_mul_cell_valid, st, 64'(mif1.A_mul_cell_result));
            score(2, mif2.A_mul_cell_valid, st, mif2.A_mul_cell_result);
            if (rv && !st) begin
                q0.push_back(ref_mul(a, b, op, 32));
                q1.push_back(ref_mul(a, b, op, 16));
                q2.push_back(ref_mul(a, b, op, 64));
            end
            @(posedge clk); #1;
        end
        check("rnd0_drain", 64'(q0.size()), 64'd0);
        check("rnd1_drain", 64'(q1.size()), 64'd0);
        check("rnd2_drain", 64'(q2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
